// File: rtl/delay_chain_len_ctrl.sv
// Length-reconfiguration controller for the memory-based delay chain.
// Accepts range-checked length requests and flags dout valid once the chain has been refilled.
module delay_chain_len_ctrl #(
  parameter int MAX_LEN = 32,
  parameter int MIN_LEN = 2,
  parameter int RST_LEN = MAX_LEN,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_vld,
  input  logic [LW-1:0] cfg_len,
  output logic          cfg_rdy,
  output logic          cfg_err,
  input  logic          en_in,
  output logic          chain_en,
  output logic [LW-1:0] chain_len,
  output logic          dout_vld,
  output logic          busy
);

  typedef enum logic {RUN, FILL} state_e;

  localparam logic [LW-1:0] MinLenC = LW'(MIN_LEN);
  localparam logic [LW-1:0] MaxLenC = LW'(MAX_LEN);
  localparam logic [LW-1:0] RstLenC = LW'(RST_LEN);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] fill_cnt_q, fill_cnt_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;

  // A zero-length chain is a combinational path, so it never needs a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= RstLenC;
      fill_cnt_q <= '0;
      err_q      <= 1'b0;
      if (RST_LEN == 0) begin
        state_q <= RUN;
        vld_q   <= 1'b1;
      end else begin
        state_q <= FILL;
        vld_q   <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      fill_cnt_q <= fill_cnt_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    fill_cnt_d = fill_cnt_q;
    vld_d      = vld_q;
    err_d      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (cfg_vld) begin
          if ((cfg_len < MinLenC) || (cfg_len > MaxLenC)) begin
            err_d = 1'b1;
          end else if (cfg_len != len_q) begin
            len_d = cfg_len;
            if (cfg_len != '0) begin
              fill_cnt_d = '0;
              vld_d      = 1'b0;
              state_d    = FILL;
            end
          end
        end
      end
      FILL: begin
        // Only real samples refill the chain; idle cycles freeze the count.
        if (en_in) begin
          fill_cnt_d = fill_cnt_q + LW'(1);
          if (fill_cnt_q == len_q - LW'(1)) begin
            vld_d   = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign cfg_rdy   = (state_q == RUN);
  assign busy      = (state_q == FILL);
  assign cfg_err   = err_q;
  assign chain_en  = en_in;
  assign chain_len = len_q;
  assign dout_vld  = vld_q;

endmodule

// File: tb/tb_delay_chain_len_ctrl.sv
// Randomized self-checking bench for delay_chain_len_ctrl against a countdown-based
// reference model: a refill is "pulses still owed to the chain", valid when none are owed.
module tb_delay_chain_len_ctrl;

  localparam int MAX_LEN = 32;
  localparam int MIN_LEN = 2;
  localparam int RST_LEN = MAX_LEN;
  localparam int LW = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rstIn = 1'b1;
  logic          cfgVld = 1'b0;
  logic [LW-1:0] cfgLen = '0;
  logic          enIn = 1'b0;
  logic          cfgRdy, cfgErr, chainEn, doutVld, busy;
  logic [LW-1:0] chainLen;

  int compareCount = 0;
  int mismatchCount = 0;

  int mLen = RST_LEN;
  int mRemain = RST_LEN;
  bit mErr = 1'b0;

  delay_chain_len_ctrl #(
    .MAX_LEN(MAX_LEN),
    .MIN_LEN(MIN_LEN),
    .RST_LEN(RST_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rstIn),
    .cfg_vld  (cfgVld),
    .cfg_len  (cfgLen),
    .cfg_rdy  (cfgRdy),
    .cfg_err  (cfgErr),
    .en_in    (enIn),
    .chain_en (chainEn),
    .chain_len(chainLen),
    .dout_vld (doutVld),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Model: a new legal length owes that many enabled samples before dout is valid.
  task automatic modelStep();
    if (rstIn) begin
      mLen = RST_LEN;
      mRemain = RST_LEN;
      mErr = 1'b0;
    end else begin
      mErr = 1'b0;
      if (mRemain > 0) begin
        if (enIn) mRemain--;
      end else if (cfgVld) begin
        if (int'(cfgLen) < MIN_LEN || int'(cfgLen) > MAX_LEN) begin
          mErr = 1'b1;
        end else if (int'(cfgLen) != mLen) begin
          mLen = int'(cfgLen);
          mRemain = int'(cfgLen);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v, input logic [LW-1:0] l);
    rstIn = r;
    enIn = e;
    cfgVld = v;
    cfgLen = l;
    #1;
    checkOutput("chain_en", int'(chainEn), int'(e));
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("cfg_rdy", int'(cfgRdy), int'(mRemain == 0));
    checkOutput("busy", int'(busy), int'(mRemain > 0));
    checkOutput("dout_vld", int'(doutVld), int'(mRemain == 0));
    checkOutput("cfg_err", int'(cfgErr), int'(mErr));
    checkOutput("chain_len", int'(chainLen), mLen);
  endtask

  int lowCnt;
  logic [LW-1:0] reqLen;
  bit reqPend;
  bit wasRdy;
  logic rr, ee;

  initial begin
    // Reset, then refill of RST_LEN with en held high.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    lowCnt = 0;
    for (int i = 0; i < 200 && !doutVld; i++) begin
      lowCnt++;
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
    end
    checkOutput("fill_rst_len", lowCnt, RST_LEN);

    applyStimulus(1'b0, 1'b1, 1'b1, LW'(5));
    lowCnt = 0;
    for (int i = 0; i < 200 && !doutVld; i++) begin
      lowCnt++;
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
    end
    checkOutput("fill_len5", lowCnt, 5);

    applyStimulus(1'b0, 1'b1, 1'b1, LW'(8));
    lowCnt = 0;
    for (int i = 0; i < 200 && !doutVld; i++) begin
      lowCnt++;
      applyStimulus(1'b0, (i % 2) == 0, 1'b0, '0);
    end
    checkOutput("fill_len8_toggle", lowCnt, 15);

    applyStimulus(1'b0, 1'b1, 1'b1, LW'(1));
    checkOutput("err_len1", int'(cfgErr), 1);
    applyStimulus(1'b0, 1'b1, 1'b1, LW'(33));
    checkOutput("err_len33", int'(cfgErr), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("len_after_err", int'(chainLen), 8);

    applyStimulus(1'b0, 1'b1, 1'b1, LW'(8));
    checkOutput("noop_vld", int'(doutVld), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);

    applyStimulus(1'b0, 1'b1, 1'b1, LW'(10));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, LW'(7));
    applyStimulus(1'b1, 1'b1, 1'b1, LW'(7));
    checkOutput("rst_mid_fill_len", int'(chainLen), RST_LEN);
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, 1'b1, mLen != 7, LW'(7));
    checkOutput("held_req_len", int'(chainLen), 7);

    // Random traffic with a requester that holds each request until accepted.
    reqPend = 1'b0;
    reqLen = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!reqPend && $urandom_range(0, 3) == 0) begin
        reqPend = 1'b1;
        if ($urandom_range(0, 4) == 0) reqLen = LW'(mLen);
        else reqLen = LW'($urandom_range(0, 40));
      end
      rr = ($urandom_range(0, 199) == 0);
      ee = ($urandom_range(0, 9) < 7);
      wasRdy = (mRemain == 0);
      applyStimulus(rr, ee, reqPend, reqLen);
      if (reqPend && wasRdy && !rr) reqPend = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
